axi_native_bridge: RTL and testbench

AXI_NATIVE_BRIDGE -- requirements
Module: axi_native_bridge

---
 rtl/axi_native_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_native_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_native_bridge.sv
// rtl/axi_native_bridge.sv - AXI write/read channels to a beat-by-beat native command/data port
//
// Purpose: accepts one AXI burst at a time (write or read), issues one native
// command per beat with a word address, passes W data out to the native write
// port and native read data back to R, and closes writes with a single B.
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   axi_aw_* / axi_w_* / axi_b_*   AXI write address, data, response
//   axi_ar_* / axi_r_*             AXI read address, data
//   native_cmd_*            per-beat command (word address, write enable, framing)
//   wdata_*                 per-beat write data toward the native side
//   rdata_*                 per-beat read data from the native side
module axi_native_bridge #(
  parameter int ADDR_SHIFT = 5
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         axi_aw_valid,
  output logic         axi_aw_ready,
  input  logic [31:0]  axi_aw_payload_addr,
  input  logic [7:0]   axi_aw_payload_len,
  input  logic         axi_aw_payload_id,
  input  logic         axi_aw_payload_burst,
  input  logic         axi_aw_payload_size,
  input  logic         axi_aw_payload_lock,
  input  logic         axi_aw_payload_prot,
  input  logic         axi_aw_payload_cache,
  input  logic         axi_aw_payload_qos,
  input  logic         axi_aw_first,
  input  logic         axi_aw_last,
  input  logic         axi_w_valid,
  output logic         axi_w_ready,
  input  logic [255:0] axi_w_payload_data,
  input  logic [31:0]  axi_w_payload_strb,
  input  logic         axi_w_payload_id,
  input  logic         axi_w_first,
  input  logic         axi_w_last,
  output logic         axi_b_valid,
  output logic         axi_b_first,
  output logic         axi_b_last,
  input  logic         axi_b_ready,
  output logic [1:0]   axi_b_payload_resp,
  output logic         axi_b_payload_id,
  input  logic         axi_ar_valid,
  output logic         axi_ar_ready,
  input  logic [31:0]  axi_ar_payload_addr,
  input  logic [7:0]   axi_ar_payload_len,
  input  logic         axi_ar_payload_id,
  input  logic         axi_ar_payload_burst,
  input  logic         axi_ar_payload_size,
  input  logic         axi_ar_payload_lock,
  input  logic         axi_ar_payload_prot,
  input  logic         axi_ar_payload_cache,
  input  logic         axi_ar_payload_qos,
  input  logic         axi_ar_first,
  input  logic         axi_ar_last,
  output logic         axi_r_valid,
  output logic         axi_r_first,
  output logic         axi_r_last,
  input  logic         axi_r_ready,
  output logic [255:0] axi_r_payload_data,
  output logic [1:0]   axi_r_payload_resp,
  output logic         axi_r_payload_id,
  output logic         native_cmd_valid,
  output logic         native_cmd_first,
  output logic         native_cmd_last,
  output logic         native_cmd_payload_we,
  output logic [31:0]  native_cmd_payload_addr,
  input  logic         native_cmd_ready,
  output logic         wdata_valid,
  output logic         wdata_first,
  output logic         wdata_last,
  output logic [255:0] wdata_payload_data,
  output logic [31:0]  wdata_payload_we,
  input  logic         wdata_ready,
  input  logic         rdata_valid,
  input  logic         rdata_first,
  input  logic         rdata_last,
  input  logic [255:0] rdata_payload_data,
  output logic         rdata_ready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_CMD  = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] WR_RESP = 3'd3;
  localparam logic [2:0] RD_CMD  = 3'd4;
  localparam logic [2:0] RD_DATA = 3'd5;

  logic [2:0]   state;
  logic [31:0]  addr_q;
  logic [7:0]   len_q;
  logic [7:0]   beat_q;
  logic         id_q;
  logic         prio_wr;
  logic [255:0] wdata_hold;
  logic [31:0]  wstrb_hold;
  logic [255:0] rdata_hold;

  logic in_idle, in_cmd, in_wdata, in_rdata, beat_first, beat_last;
  logic aw_hs, ar_hs, w_hs, r_hs;

  // Framing inputs and side-band fields carry nothing this bridge needs:
  // burst length comes from len alone.
  logic unused_inputs;
  assign unused_inputs = ^{axi_aw_payload_burst, axi_aw_payload_size, axi_aw_payload_lock,
                           axi_aw_payload_prot, axi_aw_payload_cache, axi_aw_payload_qos,
                           axi_aw_first, axi_aw_last, axi_ar_payload_burst, axi_ar_payload_size,
                           axi_ar_payload_lock, axi_ar_payload_prot, axi_ar_payload_cache,
                           axi_ar_payload_qos, axi_ar_first, axi_ar_last, axi_w_payload_id,
                           axi_w_first, axi_w_last, rdata_first, rdata_last};

  // Address readies are qualified by reset because they are combinational
  // from the request valids and must read 0 for as long as reset is held.
  assign in_idle    = (state == IDLE) && !sys_rst;
  assign in_cmd     = (state == WR_CMD) || (state == RD_CMD);
  assign in_wdata   = (state == WR_DATA);
  assign in_rdata   = (state == RD_DATA);
  assign beat_first = (beat_q == 8'd0);
  assign beat_last  = (beat_q == len_q);

  assign axi_aw_ready = in_idle && axi_aw_valid && (!axi_ar_valid || prio_wr);
  assign axi_ar_ready = in_idle && axi_ar_valid && (!axi_aw_valid || !prio_wr);
  assign aw_hs = axi_aw_valid && axi_aw_ready;
  assign ar_hs = axi_ar_valid && axi_ar_ready;

  assign native_cmd_valid        = in_cmd;
  assign native_cmd_payload_we   = (state == WR_CMD);
  assign native_cmd_first        = in_cmd && beat_first;
  assign native_cmd_last         = in_cmd && beat_last;
  assign native_cmd_payload_addr = (addr_q >> ADDR_SHIFT) + {24'd0, beat_q};

  // W passes straight through while a data beat is owed; otherwise the
  // payload shows the last value seen so it never wanders between beats.
  assign wdata_valid        = in_wdata && axi_w_valid;
  assign axi_w_ready        = in_wdata && wdata_ready;
  assign wdata_first        = in_wdata && beat_first;
  assign wdata_last         = in_wdata && beat_last;
  assign wdata_payload_data = in_wdata ? axi_w_payload_data : wdata_hold;
  assign wdata_payload_we   = in_wdata ? axi_w_payload_strb : wstrb_hold;
  assign w_hs               = axi_w_valid && wdata_ready;

  assign axi_b_valid        = (state == WR_RESP);
  assign axi_b_first        = axi_b_valid;
  assign axi_b_last         = axi_b_valid;
  assign axi_b_payload_resp = 2'b00;
  assign axi_b_payload_id   = id_q;

  assign axi_r_valid        = in_rdata && rdata_valid;
  assign rdata_ready        = in_rdata && axi_r_ready;
  assign axi_r_first        = in_rdata && beat_first;
  assign axi_r_last         = in_rdata && beat_last;
  assign axi_r_payload_data = in_rdata ? rdata_payload_data : rdata_hold;
  assign axi_r_payload_resp = 2'b00;
  assign axi_r_payload_id   = id_q;
  assign r_hs               = rdata_valid && axi_r_ready;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      id_q       <= 1'b0;
      prio_wr    <= 1'b1;
      wdata_hold <= '0;
      wstrb_hold <= '0;
      rdata_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            addr_q  <= axi_aw_payload_addr;
            len_q   <= axi_aw_payload_len;
            id_q    <= axi_aw_payload_id;
            beat_q  <= 8'd0;
            prio_wr <= ~prio_wr;
            state   <= WR_CMD;
          end else if (ar_hs) begin
            addr_q  <= axi_ar_payload_addr;
            len_q   <= axi_ar_payload_len;
            id_q    <= axi_ar_payload_id;
            beat_q  <= 8'd0;
            prio_wr <= ~prio_wr;
            state   <= RD_CMD;
          end
        end
        WR_CMD: if (native_cmd_ready) state <= WR_DATA;
        RD_CMD: if (native_cmd_ready) state <= RD_DATA;
        WR_DATA: begin
          wdata_hold <= axi_w_payload_data;
          wstrb_hold <= axi_w_payload_strb;
          // Compare before incrementing so len == 255 completes at beat 255.
          if (w_hs) begin
            if (beat_last) begin
              state <= WR_RESP;
            end else begin
              beat_q <= beat_q + 8'd1;
              state  <= WR_CMD;
            end
          end
        end
        WR_RESP: if (axi_b_ready) state <= IDLE;
        RD_DATA: begin
          rdata_hold <= rdata_payload_data;
          if (r_hs) begin
            if (beat_last) begin
              state <= IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
              state  <= RD_CMD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_native_bridge.sv
// tb/tb_axi_native_bridge.sv - randomized self-checking bench for axi_native_bridge
module tb_axi_native_bridge;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b0;
  logic         ign = 1'b0;
  logic         axi_aw_valid = 1'b0, axi_aw_ready;
  logic [31:0]  axi_aw_payload_addr = '0;
  logic [7:0]   axi_aw_payload_len = '0;
  logic         axi_aw_payload_id = 1'b0;
  logic         axi_w_valid = 1'b0, axi_w_ready;
  logic [255:0] axi_w_payload_data = '0;
  logic [31:0]  axi_w_payload_strb = '0;
  logic         axi_b_valid, axi_b_first, axi_b_last, axi_b_ready = 1'b0;
  logic [1:0]   axi_b_payload_resp;
  logic         axi_b_payload_id;
  logic         axi_ar_valid = 1'b0, axi_ar_ready;
  logic [31:0]  axi_ar_payload_addr = '0;
  logic [7:0]   axi_ar_payload_len = '0;
  logic         axi_ar_payload_id = 1'b0;
  logic         axi_r_valid, axi_r_first, axi_r_last, axi_r_ready = 1'b0;
  logic [255:0] axi_r_payload_data;
  logic [1:0]   axi_r_payload_resp;
  logic         axi_r_payload_id;
  logic         native_cmd_valid, native_cmd_first, native_cmd_last, native_cmd_payload_we;
  logic [31:0]  native_cmd_payload_addr;
  logic         native_cmd_ready = 1'b0;
  logic         wdata_valid, wdata_first, wdata_last, wdata_ready = 1'b0;
  logic [255:0] wdata_payload_data;
  logic [31:0]  wdata_payload_we;
  logic         rdata_valid = 1'b0, rdata_ready;
  logic [255:0] rdata_payload_data = '0;

  int  n_checks = 0;
  int  n_pass = 0;
  bit  prio_wr_m = 1'b1;
  bit  press_aw = 1'b0;

  always #5 sys_clk = ~sys_clk;

  axi_native_bridge #(.ADDR_SHIFT(5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_aw_payload_addr(axi_aw_payload_addr), .axi_aw_payload_len(axi_aw_payload_len),
    .axi_aw_payload_id(axi_aw_payload_id), .axi_aw_payload_burst(ign), .axi_aw_payload_size(ign),
    .axi_aw_payload_lock(ign), .axi_aw_payload_prot(ign), .axi_aw_payload_cache(ign),
    .axi_aw_payload_qos(ign), .axi_aw_first(ign), .axi_aw_last(ign),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_payload_data(axi_w_payload_data),
    .axi_w_payload_strb(axi_w_payload_strb), .axi_w_payload_id(ign), .axi_w_first(ign), .axi_w_last(ign),
    .axi_b_valid(axi_b_valid), .axi_b_first(axi_b_first), .axi_b_last(axi_b_last),
    .axi_b_ready(axi_b_ready), .axi_b_payload_resp(axi_b_payload_resp), .axi_b_payload_id(axi_b_payload_id),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_payload_addr(axi_ar_payload_addr), .axi_ar_payload_len(axi_ar_payload_len),
    .axi_ar_payload_id(axi_ar_payload_id), .axi_ar_payload_burst(ign), .axi_ar_payload_size(ign),
    .axi_ar_payload_lock(ign), .axi_ar_payload_prot(ign), .axi_ar_payload_cache(ign),
    .axi_ar_payload_qos(ign), .axi_ar_first(ign), .axi_ar_last(ign),
    .axi_r_valid(axi_r_valid), .axi_r_first(axi_r_first), .axi_r_last(axi_r_last),
    .axi_r_ready(axi_r_ready), .axi_r_payload_data(axi_r_payload_data),
    .axi_r_payload_resp(axi_r_payload_resp), .axi_r_payload_id(axi_r_payload_id),
    .native_cmd_valid(native_cmd_valid), .native_cmd_first(native_cmd_first),
    .native_cmd_last(native_cmd_last), .native_cmd_payload_we(native_cmd_payload_we),
    .native_cmd_payload_addr(native_cmd_payload_addr), .native_cmd_ready(native_cmd_ready),
    .wdata_valid(wdata_valid), .wdata_first(wdata_first), .wdata_last(wdata_last),
    .wdata_payload_data(wdata_payload_data), .wdata_payload_we(wdata_payload_we),
    .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata_first(ign), .rdata_last(ign),
    .rdata_payload_data(rdata_payload_data), .rdata_ready(rdata_ready)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_all_idle_outputs(input string tag);
    check({tag, "_cmd_valid"}, native_cmd_valid, 0);
    check({tag, "_wdata_valid"}, wdata_valid, 0);
    check({tag, "_w_ready"}, axi_w_ready, 0);
    check({tag, "_b_valid"}, axi_b_valid, 0);
    check({tag, "_aw_ready"}, axi_aw_ready, 0);
    check({tag, "_ar_ready"}, axi_ar_ready, 0);
    check({tag, "_r_valid"}, axi_r_valid, 0);
    check({tag, "_rdata_ready"}, rdata_ready, 0);
    check({tag, "_cmd_addr"}, native_cmd_payload_addr, 0);
    check({tag, "_wdata_data"}, wdata_payload_data, 0);
    check({tag, "_r_data"}, axi_r_payload_data, 0);
  endtask

  // Address phase: called just after a rising edge; the grant is judged
  // against a priority flag that flips on every grant and restarts at write.
  task automatic issue(input bit want_aw, input bit want_ar, output bit got_wr);
    bit exp_wr;
    axi_aw_valid = want_aw;
    axi_ar_valid = want_ar;
    #3;
    exp_wr = want_aw && (!want_ar || prio_wr_m);
    check("aw_grant", axi_aw_ready, exp_wr);
    check("ar_grant", axi_ar_ready, !exp_wr);
    got_wr = exp_wr;
    prio_wr_m = !prio_wr_m;
    @(posedge sys_clk); #1;
    if (exp_wr) axi_aw_valid = 1'b0; else axi_ar_valid = 1'b0;
  endtask

  // Transaction model: beat k needs command k, then data k, in that order;
  // command address is the byte address in 32-byte words plus k.
  task automatic body(input bit wr, input logic [31:0] addr, input int len, input bit id,
                      input int stall0, input int bstall, input int rst_beat);
    int ci, di, bseen;
    bit done, aborted, in_data;
    logic [255:0] wd, rd, last_wd;
    logic [31:0] ws, base;
    base = addr >> 5;
    ci = 0; di = 0; bseen = 0; done = 0; aborted = 0;
    wd = rnd256(); rd = rnd256(); ws = $urandom(); last_wd = '0;
    if (press_aw) begin axi_aw_valid = 1'b1; axi_ar_valid = 1'b1; end
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      ign                = $urandom_range(0, 1) != 0;
      native_cmd_ready   = (cyc < stall0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      wdata_ready        = $urandom_range(0, 3) != 0;
      axi_w_valid        = $urandom_range(0, 3) != 0;
      axi_w_payload_data = wd;
      axi_w_payload_strb = ws;
      axi_b_ready        = (bseen < bstall) ? 1'b0 : ($urandom_range(0, 1) != 0);
      rdata_valid        = $urandom_range(0, 3) != 0;
      rdata_payload_data = rd;
      axi_r_ready        = $urandom_range(0, 3) != 0;
      #3;
      in_data = (ci == di + 1);
      if (rst_beat >= 0 && wr && di == rst_beat && in_data) begin
        sys_rst = 1'b1;
        #1;
        check_all_idle_outputs("midrst");
        @(posedge sys_clk); #1;
        check_all_idle_outputs("midrst_edge");
        sys_rst = 1'b0;
        prio_wr_m = 1'b1;
        aborted = 1'b1;
        break;
      end
      check("aw_ready_busy", axi_aw_ready, 0);
      check("ar_ready_busy", axi_ar_ready, 0);
      check("cmd_valid", native_cmd_valid, ci == di && di <= len);
      check("wdata_valid", wdata_valid, wr && in_data && axi_w_valid);
      check("w_ready", axi_w_ready, wr && in_data && wdata_ready);
      check("r_valid", axi_r_valid, !wr && in_data && rdata_valid);
      check("rdata_ready", rdata_ready, !wr && in_data && axi_r_ready);
      check("b_valid", axi_b_valid, wr && di == len + 1);
      if (wr && di == len + 1) begin
        bseen++;
        check("b_id_hold", axi_b_payload_id, id);
        check("wdata_hold", wdata_payload_data, last_wd);
      end
      if (native_cmd_valid && native_cmd_ready) begin
        check("cmd_addr", native_cmd_payload_addr, base + ci);
        check("cmd_we", native_cmd_payload_we, wr);
        check("cmd_first", native_cmd_first, ci == 0);
        check("cmd_last", native_cmd_last, ci == len);
        check("cmd_order", ci, di);
        ci++;
      end
      if (wdata_valid && wdata_ready) begin
        check("wd_data", wdata_payload_data, wd);
        check("wd_we", wdata_payload_we, ws);
        check("wd_first", wdata_first, di == 0);
        check("wd_last", wdata_last, di == len);
        check("wd_order", ci, di + 1);
        last_wd = wd;
        di++;
        wd = rnd256(); ws = $urandom();
      end
      if (axi_r_valid && axi_r_ready) begin
        check("r_data", axi_r_payload_data, rd);
        check("r_resp", axi_r_payload_resp, 0);
        check("r_id", axi_r_payload_id, id);
        check("r_first", axi_r_first, di == 0);
        check("r_last", axi_r_last, di == len);
        check("r_order", ci, di + 1);
        di++;
        rd = rnd256();
        if (di == len + 1) done = 1'b1;
      end
      if (axi_b_valid && axi_b_ready) begin
        check("b_beats", di, len + 1);
        check("b_resp", axi_b_payload_resp, 0);
        check("b_id", axi_b_payload_id, id);
        check("b_frame", {axi_b_first, axi_b_last}, 2'b11);
        done = 1'b1;
      end
      @(posedge sys_clk); #1;
    end
    if (!aborted) check("txn_done", done, 1);
    axi_w_valid = 0; rdata_valid = 0; native_cmd_ready = 0;
    wdata_ready = 0; axi_b_ready = 0; axi_r_ready = 0;
    press_aw = 1'b0;
  endtask

  task automatic run(input bit want_aw, input bit want_ar, input int stall0, input int bstall,
                     input int rst_beat, output bit g);
    issue(want_aw, want_ar, g);
    if (g) body(1'b1, axi_aw_payload_addr, int'(axi_aw_payload_len), axi_aw_payload_id, stall0, bstall, rst_beat);
    else   body(1'b0, axi_ar_payload_addr, int'(axi_ar_payload_len), axi_ar_payload_id, stall0, bstall, rst_beat);
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic i);
    axi_aw_payload_addr = a; axi_aw_payload_len = l; axi_aw_payload_id = i;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic i);
    axi_ar_payload_addr = a; axi_ar_payload_len = l; axi_ar_payload_id = i;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit g;
    #2;
    sys_rst = 1'b1;
    axi_aw_valid = 1; axi_ar_valid = 1; axi_w_valid = 1; rdata_valid = 1;
    native_cmd_ready = 1; wdata_ready = 1; axi_b_ready = 1; axi_r_ready = 1;
    #1;
    check_all_idle_outputs("reset");
    repeat (2) @(posedge sys_clk);
    #1;
    check_all_idle_outputs("reset_clk");
    axi_aw_valid = 0; axi_ar_valid = 0; axi_w_valid = 0; rdata_valid = 0;
    native_cmd_ready = 0; wdata_ready = 0; axi_b_ready = 0; axi_r_ready = 0;
    sys_rst = 1'b0;
    prio_wr_m = 1'b1;

    // Single write right after reset release, then the burst read with a
    // held-off first command.
    set_aw(32'h40, 8'd0, 1'b1);
    run(1, 0, 0, 0, -1, g);
    set_ar(32'h100, 8'd3, 1'b0);
    run(0, 1, 2, 0, -1, g);

    // Two simultaneous pairs: grants follow the alternating priority flag.
    for (int p = 0; p < 2; p++) begin
      set_aw($urandom(), 8'($urandom_range(0, 3)), 1'($urandom()));
      set_ar($urandom(), 8'($urandom_range(0, 3)), 1'($urandom()));
      run(1, 1, 0, 0, -1, g);
      if (g) run(0, 1, 0, 0, -1, g); else run(1, 0, 0, 0, -1, g);
    end

    // Held-off B with both address channels pressing the whole time.
    set_aw(32'h2000, 8'd1, 1'b1);
    set_ar(32'h3000, 8'd0, 1'b0);
    press_aw = 1'b1;
    run(1, 0, 0, 5, -1, g);
    run(1, 1, 0, 0, -1, g);
    if (g) run(0, 1, 0, 0, -1, g); else run(1, 0, 0, 0, -1, g);

    // Word address crossing into the next 2^27 region.
    set_aw(32'hFFFFFFE0, 8'd1, 1'b0);
    run(1, 0, 0, 0, -1, g);

    // Reset during beat 2 of an 8-beat write, then a clean write.
    set_aw(32'h0000_1240, 8'd7, 1'b1);
    run(1, 0, 0, 0, 2, g);
    axi_b_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      check("post_rst_no_b", axi_b_valid, 0);
      @(posedge sys_clk); #1;
    end
    axi_b_ready = 1'b0;
    set_aw(32'h0000_0800, 8'd2, 1'b0);
    run(1, 0, 0, 0, -1, g);

    // Longest bursts.
    set_aw($urandom(), 8'd255, 1'b1);
    run(1, 0, 0, 0, -1, g);
    set_ar($urandom(), 8'd255, 1'b1);
    run(0, 1, 0, 0, -1, g);

    // Random mix of single and simultaneous requests.
    for (int it = 0; it < 24; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      set_aw($urandom(), 8'($urandom_range(0, 6)), 1'($urandom()));
      set_ar($urandom(), 8'($urandom_range(0, 6)), 1'($urandom()));
      if (mode == 0) run(1, 0, $urandom_range(0, 2), $urandom_range(0, 3), -1, g);
      else if (mode == 1) run(0, 1, $urandom_range(0, 2), 0, -1, g);
      else begin
        run(1, 1, 0, 0, -1, g);
        if (g) run(0, 1, 0, 0, -1, g); else run(1, 0, 0, 0, -1, g);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
